// File: rtl/dm_pkg.sv
// Shared definitions for the data memory responder.
//   dm_state_e             : responder FSM states (IDLE, WAIT, RESP)
//   DM_DEPTH_WORDS_DEFAULT : default number of 32-bit words stored
//   DM_WAIT_CNT_W          : width of the read wait-state down-counter
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam int unsigned DM_DEPTH_WORDS_DEFAULT = 3072;
  localparam int unsigned DM_WAIT_CNT_W          = 4;

endpackage

// File: rtl/dm_byte_merge.sv
// Combinational byte-lane merge: replaces each byte lane of old_word whose
// byteen bit is set with the matching lane of wdata.
//   old_word : current memory word
//   wdata    : lane-replicated write data
//   byteen   : per-byte lane enable
//   new_word : merged word to store
module dm_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] new_word
);

  always_comb begin
    new_word = old_word;
    for (int unsigned i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        new_word[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with byte-lane writes and a fixed-latency read
// responder. Writes complete on the accepting edge with no stall; reads
// return after WAIT_CYCLES+1 cycles with a one-cycle m_data_ready pulse.
// Out-of-range accesses are suppressed (reads return 0) and flagged on
// addr_err one cycle later.
//
// Parameters:
//   DEPTH_WORDS : number of 32-bit words (byte addresses 0 .. 4*DEPTH_WORDS-1)
//   WAIT_CYCLES : extra read wait states, 0..15
// Ports:
//   clk           : clock, rising edge
//   reset         : asynchronous active-low reset (also clears the memory)
//   m_inst_addr   : PC of the issuing instruction, used only for write logging
//   m_data_addr   : byte address of the access
//   m_data_wdata  : write data, lane-replicated
//   m_data_byteen : byte write enable, nonzero = write request
//   m_data_req    : read request
//   m_data_rdata  : aligned read word, held until the next accepted read
//   m_data_ready  : one-cycle pulse, m_data_rdata valid
//   m_data_busy   : read in flight, requests ignored
//   addr_err      : pulses one cycle after an accepted out-of-range access
// Build option:
//   DM_WRITE_LOG_EN : when defined, each accepted write is printed as
//                     "@<pc>: *<word address> <= <merged word>"
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DM_DEPTH_WORDS_DEFAULT,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_inst_addr,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic        m_data_req,
  output logic [31:0] m_data_rdata,
  output logic        m_data_ready,
  output logic        m_data_busy,
  output logic        addr_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dm_state_e                  state;
  logic [DM_WAIT_CNT_W-1:0]   wait_cnt;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          in_range;
  logic          idle;
  logic          wr_fire;
  logic          acc_err;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;

  assign word_idx = m_data_addr[31:2];
  assign mem_idx  = word_idx[AW-1:0];
  assign in_range = (word_idx < 30'(DEPTH_WORDS));
  assign idle     = (state == IDLE);
  assign wr_fire  = idle && (m_data_byteen != '0) && in_range;
  assign acc_err  = idle && (m_data_req || (m_data_byteen != '0)) && !in_range;

  // Out-of-range words never index the array; they read as zero.
  assign cur_word = in_range ? mem[mem_idx] : '0;

  assign m_data_busy = (state != IDLE);

  dm_byte_merge u_merge (
    .old_word (cur_word),
    .wdata    (m_data_wdata),
    .byteen   (m_data_byteen),
    .new_word (merged_word)
  );

  // Storage. The read snapshot below samples cur_word on the same edge, so a
  // simultaneous read returns the pre-write word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_fire) begin
      mem[mem_idx] <= merged_word;
`ifdef DM_WRITE_LOG_EN
      $display("@%h: *%h <= %h", m_inst_addr, {word_idx, 2'b00}, merged_word);
`endif
    end
  end

`ifndef DM_WRITE_LOG_EN
  logic unused_inputs;
  assign unused_inputs = ^{m_inst_addr, m_data_addr[1:0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^m_data_addr[1:0];
`endif

  // Read responder FSM. m_data_ready is registered and raised on the edge
  // that enters RESP, so it is high exactly while state == RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      m_data_rdata <= '0;
      m_data_ready <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      m_data_ready <= 1'b0;
      addr_err     <= acc_err;
      case (state)
        IDLE: begin
          if (m_data_req) begin
            m_data_rdata <= cur_word;
            if (WAIT_CYCLES == 0) begin
              state        <= RESP;
              m_data_ready <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= DM_WAIT_CNT_W'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (wait_cnt <= DM_WAIT_CNT_W'(1)) begin
            state        <= RESP;
            wait_cnt     <= '0;
            m_data_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] iaddr  [2];
  logic [31:0] waddr  [2];
  logic [31:0] wdata  [2];
  logic [3:0]  byteen [2];
  logic        req    [2];
  logic [31:0] rdata  [2];
  logic        ready  [2];
  logic        busy   [2];
  logic        aerr   [2];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .m_inst_addr(iaddr[0]), .m_data_addr(waddr[0]),
    .m_data_wdata(wdata[0]), .m_data_byteen(byteen[0]), .m_data_req(req[0]),
    .m_data_rdata(rdata[0]), .m_data_ready(ready[0]), .m_data_busy(busy[0]),
    .addr_err(aerr[0])
  );

  data_mem_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .m_inst_addr(iaddr[1]), .m_data_addr(waddr[1]),
    .m_data_wdata(wdata[1]), .m_data_byteen(byteen[1]), .m_data_req(req[1]),
    .m_data_rdata(rdata[1]), .m_data_ready(ready[1]), .m_data_busy(busy[1]),
    .addr_err(aerr[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] data);
    exp_t e;
    e.data = data;
    e.due  = cyc + 1 + wait_of(d);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: every ready pulse is matched against the scoreboard.
  task automatic check_ready(input int d);
    exp_t e;
    if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_unexpected dut%0d: got ready at cycle %0d expected none", d, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      chk($sformatf("rdata dut%0d", d), rdata[d], e.data);
      n_cmp++;
      if (cyc != e.due) begin
        n_bad++;
        $display("FAIL ready_cycle dut%0d: got cycle %0d expected %0d", d, cyc, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d] === 1'b1) check_ready(d);
    end
  end

  task automatic wait_idle(input int d);
    int k = 0;
    while (busy[d] && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (busy[d]) begin
      n_bad++;
      $display("FAIL idle_timeout dut%0d: got busy=1 expected busy=0 within 40 cycles", d);
    end
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    iaddr[d]  = 32'h0000_0100 + 32'(cyc);
    waddr[d]  = a;
    wdata[d]  = data;
    byteen[d] = be;
    @(negedge clk);
    byteen[d] = '0;
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    waddr[d] = a;
    req[d]   = 1'b1;
    push(d, exp);
    @(negedge clk);
    req[d] = 1'b0;
    wait_idle(d);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      iaddr[d] = '0; waddr[d] = '0; wdata[d] = '0; byteen[d] = '0; req[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_rdata%0d", d), rdata[d], 32'h0);
      chk($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'h0);
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'h0);
      chk($sformatf("rst_aerr%0d", d), 32'(aerr[d]), 32'h0);
    end
    reset = 1'b1;

    // Full-word write then read, zero wait states
    wr(0, 32'h10, 32'h1234_5678, 4'b1111);
    rd(0, 32'h10, 32'h1234_5678);

    // Single-lane write at an unaligned address selects the same word
    wr(0, 32'h12, 32'hAAAA_AAAA, 4'b0100);
    rd(0, 32'h10, 32'h12AA_5678);

    // Mixed lanes
    wr(0, 32'h13, 32'h9999_9999, 4'b1001);
    rd(0, 32'h10, 32'h99AA_5699);

    // Simultaneous write and read returns the pre-write word
    @(negedge clk);
    waddr[0] = 32'h20; wdata[0] = 32'hFFFF_FFFF; byteen[0] = 4'b1111; req[0] = 1'b1;
    push(0, 32'h0);
    @(negedge clk);
    byteen[0] = '0; req[0] = 1'b0;
    wait_idle(0);
    rd(0, 32'h20, 32'hFFFF_FFFF);

    // Last in-range word
    wr(0, 32'h2FFC, 32'hCAFE_F00D, 4'b1111);
    chk("aerr_last_word", 32'(aerr[0]), 32'h0);
    rd(0, 32'h2FFC, 32'hCAFE_F00D);

    // First out-of-range word: write suppressed, error pulse, read returns 0
    wr(0, 32'h3000, 32'hDEAD_BEEF, 4'b1111);
    chk("aerr_oor_write", 32'(aerr[0]), 32'h1);
    @(negedge clk);
    chk("aerr_oor_clear", 32'(aerr[0]), 32'h0);
    rd(0, 32'h3000, 32'h0);
    rd(0, 32'h2FFC, 32'hCAFE_F00D);

    // Three wait states: busy for four cycles, write during WAIT dropped
    wr(1, 32'h10, 32'h1234_5678, 4'b1111);
    @(negedge clk);
    waddr[1] = 32'h10; req[1] = 1'b1;
    push(1, 32'h1234_5678);
    @(negedge clk);
    req[1] = 1'b0; wdata[1] = 32'hDEAD_BEEF; byteen[1] = 4'b1111;
    chk("busy_w1", 32'(busy[1]), 32'h1);
    @(negedge clk);
    byteen[1] = '0;
    chk("busy_w2", 32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("busy_w3", 32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("busy_resp", 32'(busy[1]), 32'h1);
    @(negedge clk);
    chk("busy_done", 32'(busy[1]), 32'h0);
    rd(1, 32'h10, 32'h1234_5678);
    repeat (3) @(negedge clk);
    chk("rdata_hold", rdata[1], 32'h1234_5678);

    // Reset in the middle of a WAIT aborts the read and clears memory
    wr(1, 32'h40, 32'h55AA_55AA, 4'b1111);
    @(negedge clk);
    waddr[1] = 32'h40; req[1] = 1'b1;
    push(1, 32'h55AA_55AA);
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_wait_rdata", rdata[1], 32'h0);
    chk("rst_wait_ready", 32'(ready[1]), 32'h0);
    chk("rst_wait_busy", 32'(busy[1]), 32'h0);
    chk("rst_wait_aerr", 32'(aerr[1]), 32'h0);
    q1.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    rd(1, 32'h40, 32'h0);
    rd(1, 32'h10, 32'h0);
    rd(0, 32'h20, 32'h0);

    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 3072, number of 32-bit words stored (byte addresses 0x0000_0000 .. 4*DEPTH_WORDS-1).
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, extra read wait states (range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port m_inst_addr  input  32  PC of the instruction issuing the access (logging only).
REQ-006 SHALL have port m_data_addr  input  32  byte address of access.
REQ-007 SHALL have port m_data_wdata  input  32  write data, already lane-replicated by initiator.
REQ-008 SHALL have port m_data_byteen  input  4  per-byte write enable; nonzero = write request.
REQ-009 SHALL have port m_data_req  input  1  read request.
REQ-010 SHALL have port m_data_rdata  output  32  full aligned word read.
REQ-011 SHALL have port m_data_ready  output  1  one-cycle pulse: m_data_rdata valid.
REQ-012 SHALL have port m_data_busy  output  1  high while a read is in flight; requests ignored.
REQ-013 SHALL have port addr_err  output  1  registered; high one cycle after an accepted out-of-range access.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with byteen != 0 and address in range, write byte lane i of word addr[31:2] from m_data_wdata[8i+7:8i] for each set bit i, same edge, no stall.
REQ-016 SHALL ignore addr[1:0] for word selection; lane selection by byteen only.
REQ-017 SHALL, in IDLE with m_data_req=1, snapshot word addr[31:2] into rdata register and go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-018 SHALL count WAIT_CYCLES cycles in WAIT with a 4-bit down-counter, then enter RESP.
REQ-019 SHALL assert m_data_ready exactly in RESP (one cycle), then return to IDLE; read latency = WAIT_CYCLES+1 cycles from request edge.
REQ-020 SHALL hold m_data_rdata stable from RESP until the next accepted read.
REQ-021 SHALL, on simultaneous req and byteen!=0 in IDLE, perform both; read returns the pre-write word.
REQ-022 SHALL ignore req and byteen while busy (WAIT/RESP); writes issued then are dropped.
REQ-023 SHALL, for address >= 4*DEPTH_WORDS, suppress the write, return rdata 0 on reads, and pulse addr_err.
REQ-024 SHALL treat byteen==0 with req==0 as no-op.

Reset
REQ-025 SHALL, on reset low, immediately force state IDLE, counter 0, m_data_rdata 0, m_data_ready 0, addr_err 0, and clear all memory words to 0.
REQ-026 SHALL abort any in-flight read on reset; no ready pulse follows release.

Configuration
REQ-027 SHALL, with DM_WRITE_LOG_EN defined, print per accepted write "@<m_inst_addr hex>: *<word address hex> <= <merged word hex>" at simulation time of the edge.
REQ-028 SHALL, without DM_WRITE_LOG_EN, contain no display statements; function otherwise identical.

Structure
REQ-029 SHALL place the state enum, default DEPTH_WORDS, and WAIT counter width in shared package dm_pkg.
REQ-030 SHALL implement lane merge (old word, wdata, byteen -> new word) in sub-module dm_byte_merge, combinational.

Verification
REQ-031 SHALL test: write 0x12345678 to 0x10, byteen 1111; read 0x10 -> rdata 0x12345678, ready one cycle later (WAIT_CYCLES=0).
REQ-032 SHALL test: after REQ-031, write 0xAAAAAAAA byteen 0100 at 0x12; read 0x10 -> 0x12AA5678.
REQ-033 SHALL test: WAIT_CYCLES=3, read 0x10 -> busy high 4 cycles, ready on 4th cycle after request; write issued during WAIT is dropped.
REQ-034 SHALL test: simultaneous write 0xFFFFFFFF byteen 1111 and read at 0x20 (holding 0x0) -> rdata 0x0, later read -> 0xFFFFFFFF.
REQ-035 SHALL test: write to 0x3000 (DEPTH_WORDS=3072) -> addr_err pulses, no memory change; read 0x3000 -> rdata 0.
REQ-036 SHALL test: reset low during WAIT -> outputs 0 immediately, no ready after release, prior data read back as 0.
